// File: rtl/m6502_bus_tracer_pkg.sv
// Shared definitions for the M6502 bus tracer: state encoding, trigger modes and
// entry field layout ({sync, rw, addr, data}).
package m6502_bus_tracer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPre  = 2'd1,
    StPost = 2'd2,
    StRead = 2'd3
  } state_e;

  localparam logic [1:0] TrigAddr  = 2'b00;
  localparam logic [1:0] TrigSync  = 2'b01;
  localparam logic [1:0] TrigWrite = 2'b10;
  localparam logic [1:0] TrigImm   = 2'b11;

  function automatic int unsigned off_addr(int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned off_rw(int unsigned addr_w, int unsigned data_w);
    return addr_w + data_w;
  endfunction

  function automatic int unsigned off_sync(int unsigned addr_w, int unsigned data_w);
    return addr_w + data_w + 1;
  endfunction

endpackage

// File: rtl/m6502_bus_tracer_trace_ram.sv
// Trace buffer storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module trace_ram #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 26,
  parameter int unsigned AddrW = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/m6502_bus_tracer.sv
// Bus-cycle trace capture: circular pre-trigger history, programmable post-trigger
// window, then oldest-first readout over a valid/ready port.
module m6502_bus_tracer
  import m6502_bus_tracer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned CNT_W   = $clog2(DEPTH) + 1,
  parameter int unsigned ENTRY_W = ADDR_W + DATA_W + 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               bus_valid,
  input  logic [ADDR_W-1:0]  bus_addr,
  input  logic [DATA_W-1:0]  bus_data,
  input  logic               bus_rw,
  input  logic               bus_sync,
  input  logic               arm,
  input  logic [1:0]         trig_mode,
  input  logic [ADDR_W-1:0]  trig_addr,
  input  logic [ADDR_W-1:0]  trig_mask,
  input  logic [CNT_W-1:0]   post_count,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ENTRY_W-1:0] rd_entry,
  output logic               rd_last,
  output logic               armed,
  output logic               triggered,
  output logic               done,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned AddrLsb = off_addr(DATA_W);
  localparam int unsigned RwBit   = off_rw(ADDR_W, DATA_W);
  localparam int unsigned SyncBit = off_sync(ADDR_W, DATA_W);
  localparam logic [CNT_W-1:0] Full    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MaxPost = CNT_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d, post_q, post_d, tpost_q, tpost_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   taddr_q, taddr_d, tmask_q, tmask_d;
  logic [ENTRY_W-1:0]  wr_entry, ram_rdata;
  logic [CNT_W-1:0]    count_inc;
  logic                addr_hit, hit, we, pop;

  always_comb begin
    wr_entry = '0;
    wr_entry[AddrLsb +: ADDR_W] = bus_addr;
    wr_entry[DATA_W-1:0]        = bus_data;
    wr_entry[RwBit]             = bus_rw;
    wr_entry[SyncBit]           = bus_sync;
  end

  assign addr_hit = ((bus_addr ^ taddr_q) & tmask_q) == '0;

  always_comb begin
    hit = 1'b1;
    case (mode_q)
      TrigAddr:  hit = addr_hit;
      TrigSync:  hit = addr_hit && bus_sync;
      TrigWrite: hit = addr_hit && !bus_rw;
      default:   hit = 1'b1;
    endcase
  end

  assign count_inc = (count_q == Full) ? count_q : count_q + CNT_W'(1);
  assign we  = !arm && bus_valid && (state_q == StPre || state_q == StPost);
  assign rd_valid = (state_q == StRead) && (count_q != '0);
  assign pop = rd_valid && rd_ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    post_d   = post_q;
    mode_d   = mode_q;
    taddr_d  = taddr_q;
    tmask_d  = tmask_q;
    tpost_d  = tpost_q;
    if (arm) begin
      state_d  = StPre;
      wr_ptr_d = '0;
      count_d  = '0;
      post_d   = '0;
      mode_d   = trig_mode;
      taddr_d  = trig_addr;
      tmask_d  = trig_mask;
      // Keep at least one slot so the trigger entry survives the post window.
      tpost_d  = (post_count > MaxPost) ? MaxPost : post_count;
    end else begin
      unique case (state_q)
        StPre: begin
          if (bus_valid) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_inc;
            if (hit) begin
              post_d = tpost_q;
              if (tpost_q == '0) begin
                state_d  = StRead;
                rd_ptr_d = wr_ptr_d - PTR_W'(count_d);
              end else begin
                state_d = StPost;
              end
            end
          end
        end
        StPost: begin
          if (bus_valid) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_inc;
            post_d   = post_q - CNT_W'(1);
            if (post_q == CNT_W'(1)) begin
              state_d  = StRead;
              rd_ptr_d = wr_ptr_d - PTR_W'(count_d);
            end
          end
        end
        StRead: begin
          if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
              state_d = StIdle;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      post_q   <= '0;
      mode_q   <= '0;
      taddr_q  <= '0;
      tmask_q  <= '0;
      tpost_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      post_q   <= post_d;
      mode_q   <= mode_d;
      taddr_q  <= taddr_d;
      tmask_q  <= tmask_d;
      tpost_q  <= tpost_d;
    end
  end

  trace_ram #(
    .Depth (DEPTH),
    .Width (ENTRY_W),
    .AddrW (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign rd_entry  = rd_valid ? ram_rdata : '0;
  assign rd_last   = rd_valid && (count_q == CNT_W'(1));
  assign armed     = (state_q == StPre);
  assign triggered = (state_q == StPost);
  assign done      = (state_q == StRead);
  assign count     = count_q;

endmodule

// File: tb/tb_m6502_bus_tracer.sv
// Bench for m6502_bus_tracer (DEPTH=8): queue-based capture model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_m6502_bus_tracer;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int D  = 8;
  localparam int CW = 4;
  localparam int EW = AW + DW + 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          bus_valid = 1'b0;
  logic [AW-1:0] bus_addr = '0;
  logic [DW-1:0] bus_data = '0;
  logic          bus_rw = 1'b0;
  logic          bus_sync = 1'b0;
  logic          arm = 1'b0;
  logic [1:0]    trig_mode = '0;
  logic [AW-1:0] trig_addr = '0;
  logic [AW-1:0] trig_mask = '0;
  logic [CW-1:0] post_count = '0;
  logic          rd_ready = 1'b0;
  logic          rd_valid, rd_last, armed, triggered, done;
  logic [EW-1:0] rd_entry;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  m6502_bus_tracer #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .DEPTH   (D),
    .CNT_W   (CW),
    .ENTRY_W (EW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus_valid  (bus_valid),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .bus_rw     (bus_rw),
    .bus_sync   (bus_sync),
    .arm        (arm),
    .trig_mode  (trig_mode),
    .trig_addr  (trig_addr),
    .trig_mask  (trig_mask),
    .post_count (post_count),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_entry   (rd_entry),
    .rd_last    (rd_last),
    .armed      (armed),
    .triggered  (triggered),
    .done       (done),
    .count      (count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting for trigger, 2 post window, 3 readout.
  int            m_phase = 0;
  logic [EW-1:0] m_q[$];
  int            m_left = 0;
  int            m_post = 0;
  logic [1:0]    m_mode = '0;
  logic [AW-1:0] m_ta = '0;
  logic [AW-1:0] m_tm = '0;

  function automatic bit model_hit(input logic [AW-1:0] a, input bit sync, input bit rw);
    bit match;
    match = ((a ^ m_ta) & m_tm) == '0;
    case (m_mode)
      2'd0:    return match;
      2'd1:    return match && sync;
      2'd2:    return match && !rw;
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0;
      m_q.delete();
      m_left = 0;
    end else if (arm) begin
      m_q.delete();
      m_mode  = trig_mode;
      m_ta    = trig_addr;
      m_tm    = trig_mask;
      m_post  = (int'(post_count) > D - 1) ? D - 1 : int'(post_count);
      m_phase = 1;
    end else if ((m_phase == 1 || m_phase == 2) && bus_valid) begin
      m_q.push_back({bus_sync, bus_rw, bus_addr, bus_data});
      if (m_q.size() > D) void'(m_q.pop_front());
      if (m_phase == 1) begin
        if (model_hit(bus_addr, bus_sync, bus_rw)) begin
          if (m_post == 0) m_phase = 3;
          else begin
            m_phase = 2;
            m_left  = m_post;
          end
        end
      end else begin
        m_left--;
        if (m_left == 0) m_phase = 3;
      end
    end else if (m_phase == 3 && rd_ready && m_q.size() > 0) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_phase = 0;
    end
  end

  always @(negedge clk) begin
    bit            ev;
    logic [EW-1:0] ee;
    ev = (m_phase == 3) && (m_q.size() > 0);
    if (ev) ee = m_q[0];
    else ee = '0;
    chk("rd_valid", 32'(rd_valid), 32'(ev));
    chk("rd_entry", 32'(rd_entry), 32'(ee));
    chk("rd_last", 32'(rd_last), 32'(ev && m_q.size() == 1));
    chk("armed", 32'(armed), 32'(m_phase == 1));
    chk("triggered", 32'(triggered), 32'(m_phase == 2));
    chk("done", 32'(done), 32'(m_phase == 3));
    chk("count", 32'(count), 32'(m_q.size()));
  end

  logic [EW-1:0] got_e[$];
  logic          got_last[$];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic smp(input logic [AW-1:0] a, input bit rw, input bit sync);
    bus_valid = 1'b1;
    bus_addr  = a;
    bus_data  = a[7:0] ^ 8'hA5;
    bus_rw    = rw;
    bus_sync  = sync;
    step();
    bus_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [AW-1:0] ta, input logic [AW-1:0] tm,
                        input logic [CW-1:0] pc);
    arm        = 1'b1;
    trig_mode  = m;
    trig_addr  = ta;
    trig_mask  = tm;
    post_count = pc;
    step();
    arm = 1'b0;
  endtask

  task automatic drain();
    got_e.delete();
    got_last.delete();
    rd_ready = 1'b1;
    for (int i = 0; i < 40 && done; i++) begin
      if (rd_valid) begin
        got_e.push_back(rd_entry);
        got_last.push_back(rd_last);
      end
      step();
    end
    rd_ready = 1'b0;
    if (done) chk("drain_timeout", 32'(done), 32'd0);
  endtask

  function automatic logic [AW-1:0] ga(input int i);
    logic [EW-1:0] e;
    e = got_e[i];
    return e[DW +: AW];
  endfunction

  initial begin
    int            trig_hi;
    int            pat[5];
    logic [EW-1:0] seen[5];
    logic [EW-1:0] e;
    pat = '{1, 0, 0, 1, 1};

    repeat (2) step();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_flags", 32'({armed, triggered, done, rd_valid, rd_last}), 32'd0);
    chk("reset_entry", 32'(rd_entry), 32'd0);
    reset_n = 1'b1;
    step();

    // Address trigger at 0x0010, post 3, buffer wraps.
    do_arm(2'b00, 16'h0010, 16'hFFFF, 4'd3);
    chk("s1_armed", 32'(armed), 32'd1);
    for (int a = 0; a <= 'h20; a++) smp(16'(a), 1'b1, 1'b0);
    chk("s1_done", 32'(done), 32'd1);
    drain();
    chk("s1_n", 32'(got_e.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_e.size()) begin
        chk("s1_addr", 32'(ga(i)), 32'h0C + 32'(i));
        chk("s1_last", 32'(got_last[i]), 32'(i == 7));
      end
    end
    chk("s1_count", 32'(count), 32'd0);
    chk("s1_idle", 32'({armed, triggered, done}), 32'd0);

    // Immediate trigger, post 2.
    do_arm(2'b11, 16'h0, 16'h0, 4'd2);
    trig_hi = 0;
    for (int i = 0; i < 3; i++) begin
      smp(16'h0100 + 16'(i), 1'b1, 1'b0);
      trig_hi += int'(triggered);
    end
    chk("s2_trig_cycles", 32'(trig_hi), 32'd2);
    chk("s2_count", 32'(count), 32'd3);
    drain();
    chk("s2_n", 32'(got_e.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < got_e.size()) chk("s2_addr", 32'(ga(i)), 32'h0100 + 32'(i));

    // Clamp: largest encodable post_count (15) clamps to 7.
    do_arm(2'b00, 16'h0040, 16'hFFFF, 4'd15);
    for (int a = 'h30; a <= 'h60; a++) smp(16'(a), 1'b1, 1'b0);
    drain();
    chk("s3_n", 32'(got_e.size()), 32'd8);
    if (got_e.size() == 8) begin
      chk("s3_oldest", 32'(ga(0)), 32'h0040);
      chk("s3_newest", 32'(ga(7)), 32'h0047);
    end

    // Sync-qualified trigger.
    do_arm(2'b01, 16'h0200, 16'hFFFF, 4'd0);
    smp(16'h0200, 1'b1, 1'b0);
    chk("s4_nosync_armed", 32'(armed), 32'd1);
    smp(16'h0200, 1'b1, 1'b1);
    chk("s4_sync_done", 32'(done), 32'd1);
    drain();
    chk("s4_n", 32'(got_e.size()), 32'd2);
    if (got_e.size() == 2) begin
      e = got_e[1];
      chk("s4_sync_bit", 32'(e[EW-1]), 32'd1);
    end

    // Write-qualified trigger.
    do_arm(2'b10, 16'h0300, 16'hFFFF, 4'd0);
    smp(16'h0300, 1'b1, 1'b0);
    chk("s4_read_armed", 32'(armed), 32'd1);
    smp(16'h0300, 1'b0, 1'b0);
    chk("s4_write_done", 32'(done), 32'd1);
    drain();
    chk("s4w_n", 32'(got_e.size()), 32'd2);
    if (got_e.size() == 2) begin
      e = got_e[1];
      chk("s4_rw_bit", 32'(e[EW-2]), 32'd0);
    end

    // Backpressure with rd_ready 1,0,0,1,1.
    do_arm(2'b11, 16'h0, 16'h0, 4'd4);
    for (int i = 0; i < 5; i++) smp(16'h0500 + 16'(i), 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      rd_ready = pat[k][0];
      seen[k]  = rd_entry;
      step();
    end
    rd_ready = 1'b0;
    chk("s5_e0", 32'(seen[0][DW +: AW]), 32'h0500);
    chk("s5_e1", 32'(seen[1][DW +: AW]), 32'h0501);
    chk("s5_hold", 32'(seen[2]), 32'(seen[1]));
    chk("s5_e3", 32'(seen[3][DW +: AW]), 32'h0501);
    chk("s5_e4", 32'(seen[4][DW +: AW]), 32'h0502);
    drain();
    chk("s5_rest_n", 32'(got_e.size()), 32'd2);
    if (got_e.size() == 2) begin
      chk("s5_r0", 32'(ga(0)), 32'h0503);
      chk("s5_r1", 32'(ga(1)), 32'h0504);
    end

    // Abort mid-POST by reset, then arm colliding with bus_valid.
    do_arm(2'b11, 16'h0, 16'h0, 4'd5);
    smp(16'h0600, 1'b1, 1'b0);
    smp(16'h0601, 1'b1, 1'b0);
    chk("s6_in_post", 32'(triggered), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("s6_rst_flags", 32'({armed, triggered, done, rd_valid, rd_last}), 32'd0);
    chk("s6_rst_count", 32'(count), 32'd0);
    chk("s6_rst_entry", 32'(rd_entry), 32'd0);
    step();
    reset_n   = 1'b1;
    arm       = 1'b1;
    trig_mode = 2'b11;
    bus_valid = 1'b1;
    bus_addr  = 16'h0700;
    step();
    arm       = 1'b0;
    bus_valid = 1'b0;
    chk("s6_arm_count", 32'(count), 32'd0);
    chk("s6_arm_armed", 32'(armed), 32'd1);

    // Randomized traffic against the model.
    for (int it = 0; it < 25; it++) begin
      logic [AW-1:0] mk;
      case ($urandom % 3)
        0:       mk = 16'hFFFF;
        1:       mk = 16'hFFF0;
        default: mk = 16'h000F;
      endcase
      do_arm(2'($urandom), 16'($urandom_range(0, 31)), mk, 4'($urandom_range(0, 15)));
      for (int c = 0; c < 80; c++) begin
        bus_valid = ($urandom % 4) != 0;
        bus_addr  = 16'($urandom_range(0, 31));
        bus_data  = 8'($urandom);
        bus_rw    = 1'($urandom);
        bus_sync  = 1'($urandom);
        rd_ready  = 1'($urandom);
        arm       = ($urandom % 100) == 0;
        if (arm) begin
          trig_mode  = 2'($urandom);
          trig_addr  = 16'($urandom_range(0, 31));
          trig_mask  = 16'hFFFF;
          post_count = 4'($urandom_range(0, 15));
        end
        step();
        arm = 1'b0;
      end
      bus_valid = 1'b0;
      rd_ready  = 1'b1;
      repeat (12) step();
      rd_ready = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched",
             n_cmp, n_bad);
    $fatal(1);
  end

endmodule
